pcie_ddr_arbiter: RTL and testbench

//  Shares the single DDR4 memory-controller command/data port between two requesters:
//  req 0 = PCIe DMA engine, req 1 = RDM logic.

---
 rtl/pcie_ddr_arbiter_if.sv | 52 +++++
 rtl/pcie_ddr_arbiter.sv | 158 +++++++++++++++
 tb/tb_pcie_ddr_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_ddr_arbiter_if.sv
// Requester-side and DDR-controller-side buses of pcie_ddr_arbiter.
// slave = arbiter view, master = environment (requesters + memory controller) view.
interface pcie_ddr_arbiter_if #(
  parameter int unsigned ADDR_W = 31,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DATA_W = 512
);
  logic [1:0]          req_cmd_valid;
  logic [1:0]          req_cmd_ready;
  logic [1:0]          req_cmd_wr;
  logic [2*ADDR_W-1:0] req_cmd_addr;
  logic [2*LEN_W-1:0]  req_cmd_len;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_wvalid;
  logic [1:0]          req_wlast;
  logic [1:0]          req_wready;
  logic [2*DATA_W-1:0] req_rdata;
  logic [1:0]          req_rvalid;
  logic [1:0]          req_rlast;
  logic [1:0]          req_rready;
  logic                ddr_cmd_valid;
  logic                ddr_cmd_wr;
  logic [ADDR_W-1:0]   ddr_cmd_addr;
  logic [LEN_W-1:0]    ddr_cmd_len;
  logic                ddr_cmd_ready;
  logic [DATA_W-1:0]   ddr_wdata;
  logic                ddr_wvalid;
  logic                ddr_wlast;
  logic                ddr_wready;
  logic [DATA_W-1:0]   ddr_rdata;
  logic                ddr_rvalid;
  logic                ddr_rlast;
  logic                ddr_rready;

  modport slave (
    input  req_cmd_valid, req_cmd_wr, req_cmd_addr, req_cmd_len,
    input  req_wdata, req_wvalid, req_wlast, req_rready,
    output req_cmd_ready, req_wready, req_rdata, req_rvalid, req_rlast,
    output ddr_cmd_valid, ddr_cmd_wr, ddr_cmd_addr, ddr_cmd_len,
    output ddr_wdata, ddr_wvalid, ddr_wlast, ddr_rready,
    input  ddr_cmd_ready, ddr_wready, ddr_rdata, ddr_rvalid, ddr_rlast
  );

  modport master (
    output req_cmd_valid, req_cmd_wr, req_cmd_addr, req_cmd_len,
    output req_wdata, req_wvalid, req_wlast, req_rready,
    input  req_cmd_ready, req_wready, req_rdata, req_rvalid, req_rlast,
    input  ddr_cmd_valid, ddr_cmd_wr, ddr_cmd_addr, ddr_cmd_len,
    input  ddr_wdata, ddr_wvalid, ddr_wlast, ddr_rready,
    output ddr_cmd_ready, ddr_wready, ddr_rdata, ddr_rvalid, ddr_rlast
  );
endinterface

// File: rtl/pcie_ddr_arbiter.sv
// Two-requester (PCIe DMA / RDM) arbiter for one DDR4 controller port with in-order read tag FIFO.
// Optional DDR_ARB_STATS_EN adds saturating grant/stall counters.
module pcie_ddr_arbiter #(
  parameter int unsigned ADDR_W      = 31,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned OUTSTANDING = 16
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic               ddr_calib_done,
  input  logic               user_lnk_up,
  output logic               arb_ready,
  output logic               err_sticky,
  pcie_ddr_arbiter_if.slave  bus
`ifdef DDR_ARB_STATS_EN
  ,
  output logic [31:0]        stat_grant0,
  output logic [31:0]        stat_grant1,
  output logic [31:0]        stat_stall
`endif
);

  localparam int unsigned PW = $clog2(OUTSTANDING);

  typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;

  state_t                  state, state_nx;
  logic                    g, g_nx, last_grant, wr_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [LEN_W-1:0]        len_q, beat_cnt;
  logic [1:0]              elig;
  logic                    grant_en, cmd_hs, beat_hs, push, pop;
  logic [OUTSTANDING-1:0]  tag_mem;
  logic [PW:0]             wptr, rptr;
  logic                    fifo_empty, fifo_full, head;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign head       = tag_mem[rptr[PW-1:0]];
  assign elig       = bus.req_cmd_valid & (bus.req_cmd_wr | {2{~fifo_full}});

  assign bus.ddr_cmd_wr   = wr_q;
  assign bus.ddr_cmd_addr = addr_q;
  assign bus.ddr_cmd_len  = len_q;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      arb_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      arb_ready <= ddr_calib_done & user_lnk_up;
    end
  end

  always_comb begin
    state_nx          = state;
    grant_en          = 1'b0;
    g_nx              = (&elig) ? ~last_grant : elig[1];
    cmd_hs            = 1'b0;
    beat_hs           = 1'b0;
    push              = 1'b0;
    bus.ddr_cmd_valid = 1'b0;
    bus.req_cmd_ready = '0;
    bus.ddr_wvalid    = 1'b0;
    bus.ddr_wdata     = '0;
    bus.ddr_wlast     = 1'b0;
    bus.req_wready    = '0;
    case (state)
      IDLE: begin
        if (arb_ready && (|elig)) begin
          grant_en = 1'b1;
          state_nx = CMD;
        end
      end
      CMD: begin
        bus.ddr_cmd_valid    = 1'b1;
        bus.req_cmd_ready[g] = bus.ddr_cmd_ready;
        if (bus.ddr_cmd_ready) begin
          cmd_hs   = 1'b1;
          push     = ~wr_q;
          state_nx = wr_q ? WDATA : IDLE;
        end
      end
      WDATA: begin
        bus.ddr_wvalid    = bus.req_wvalid[g];
        bus.ddr_wdata     = g ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
        bus.ddr_wlast     = (beat_cnt == len_q);
        bus.req_wready[g] = bus.ddr_wready;
        beat_hs           = bus.ddr_wvalid & bus.ddr_wready;
        if (beat_hs && bus.ddr_wlast) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read return is steered purely by the FIFO head, independent of the command FSM.
  always_comb begin
    bus.req_rvalid = '0;
    bus.ddr_rready = 1'b0;
    if (!fifo_empty) begin
      bus.req_rvalid[head] = bus.ddr_rvalid;
      bus.ddr_rready       = bus.req_rready[head];
    end
  end

  assign bus.req_rdata = {2{bus.ddr_rdata}};
  assign bus.req_rlast = {2{bus.ddr_rlast}};
  assign pop           = bus.ddr_rvalid & bus.ddr_rready & bus.ddr_rlast;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      g          <= 1'b0;
      last_grant <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      err_sticky <= 1'b0;
      tag_mem    <= '0;
      wptr       <= '0;
      rptr       <= '0;
    end else begin
      if (grant_en) begin
        g          <= g_nx;
        last_grant <= g_nx;
        wr_q       <= bus.req_cmd_wr[g_nx];
        addr_q     <= g_nx ? bus.req_cmd_addr[2*ADDR_W-1:ADDR_W] : bus.req_cmd_addr[ADDR_W-1:0];
        len_q      <= g_nx ? bus.req_cmd_len[2*LEN_W-1:LEN_W] : bus.req_cmd_len[LEN_W-1:0];
      end
      if (cmd_hs) beat_cnt <= '0;
      else if (beat_hs) beat_cnt <= beat_cnt + 1'b1;
      if ((beat_hs && (bus.req_wlast[g] != bus.ddr_wlast)) || (bus.ddr_rvalid && fifo_empty))
        err_sticky <= 1'b1;
      if (push) begin
        tag_mem[wptr[PW-1:0]] <= g;
        wptr                  <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

`ifdef DDR_ARB_STATS_EN
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_stall  <= '0;
    end else begin
      if (cmd_hs && !g && (stat_grant0 != '1)) stat_grant0 <= stat_grant0 + 1'b1;
      if (cmd_hs && g && (stat_grant1 != '1)) stat_grant1 <= stat_grant1 + 1'b1;
      if ((state == CMD) && !bus.ddr_cmd_ready && (stat_stall != '1)) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pcie_ddr_arbiter.sv
// Directed scoreboard bench for pcie_ddr_arbiter: expected DDR commands, write beats and read
// routing tags are queued when stimulus is driven and checked when the DUT handshakes.
module tb_pcie_ddr_arbiter;
  localparam int unsigned AW = 31;
  localparam int unsigned LW = 8;
  localparam int unsigned DW = 512;

  logic clk = 1'b0;
  logic sys_rst_n, ddr_calib_done, user_lnk_up, arb_ready, err_sticky;
`ifdef DDR_ARB_STATS_EN
  logic [31:0] stat_grant0, stat_grant1, stat_stall;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [63:0] exp_cmd[$];
  logic [32:0] exp_beat[$];
  logic        exp_tag[$];
  logic [1:0]  hs_cmd, hs_w;
  logic        hs_r;
  logic [31:0] rd_word = 32'hA000_0000;

  pcie_ddr_arbiter_if #(.ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) bus ();

  pcie_ddr_arbiter #(.ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .OUTSTANDING(16)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .ddr_calib_done(ddr_calib_done),
    .user_lnk_up(user_lnk_up), .arb_ready(arb_ready), .err_sticky(err_sticky), .bus(bus)
`ifdef DDR_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int unsigned r, input int unsigned k);
    return AW'(r * 32'h0010_0000 + k * 32'h40);
  endfunction

  function automatic logic [63:0] pk(input logic wr, input logic [LW-1:0] len, input logic [AW-1:0] a);
    return {24'b0, wr, len, a};
  endfunction

  // Scoreboard side: compare every DDR-side handshake against the queued expectation.
  always @(negedge clk) begin
    if (sys_rst_n) begin
      if (bus.ddr_cmd_valid && bus.ddr_cmd_ready) begin
        check("cmd_expected", exp_cmd.size() != 0, 1);
        if (exp_cmd.size() != 0)
          check("cmd_fields", pk(bus.ddr_cmd_wr, bus.ddr_cmd_len, bus.ddr_cmd_addr), exp_cmd.pop_front());
      end
      if (bus.ddr_wvalid && bus.ddr_wready) begin
        check("beat_expected", exp_beat.size() != 0, 1);
        if (exp_beat.size() != 0)
          check("beat_data_last", {bus.ddr_wlast, bus.ddr_wdata[31:0]}, exp_beat.pop_front());
      end
      if (bus.ddr_rvalid && bus.ddr_rready) begin
        check("rd_expected", exp_tag.size() != 0, 1);
        if (exp_tag.size() != 0) begin
          check("rd_route", bus.req_rvalid, exp_tag[0] ? 2'b10 : 2'b01);
          check("rd_data", {bus.req_rdata[DW +: 32], bus.req_rdata[31:0]}, {rd_word, rd_word});
          if (bus.ddr_rlast) void'(exp_tag.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    hs_cmd = bus.req_cmd_valid & bus.req_cmd_ready;
    hs_w   = bus.req_wvalid & bus.req_wready;
    hs_r   = bus.ddr_rvalid & bus.ddr_rready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int unsigned r, input logic v, input logic wr,
                         input logic [AW-1:0] a, input logic [LW-1:0] l);
    bus.req_cmd_valid[r]          = v;
    bus.req_cmd_wr[r]             = wr;
    bus.req_cmd_addr[r*AW +: AW]  = a;
    bus.req_cmd_len[r*LW +: LW]   = l;
  endtask

  task automatic set_w(input int unsigned r, input logic v, input logic [31:0] d, input logic last);
    bus.req_wvalid[r]          = v;
    bus.req_wdata[r*DW +: DW]  = {{(DW-32){1'b0}}, d};
    bus.req_wlast[r]           = last;
  endtask

  task automatic return_read(input int unsigned n);
    int unsigned b = 0;
    int unsigned budget = 0;
    bus.req_rready = 2'b11;
    bus.ddr_rvalid = 1'b1;
    bus.ddr_rlast  = (n == 1);
    bus.ddr_rdata  = {{(DW-32){1'b0}}, rd_word};
    while (b < n && budget < 50) begin
      cyc();
      budget++;
      if (hs_r) begin
        b++;
        rd_word++;
        bus.ddr_rlast = (b == n - 1);
        bus.ddr_rdata = {{(DW-32){1'b0}}, rd_word};
      end
    end
    bus.ddr_rvalid = 1'b0;
    bus.ddr_rlast  = 1'b0;
    check("rd_beats_done", b, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt[2];
    int unsigned budget, beats;
    logic done0, done1;

    sys_rst_n = 1'b0; ddr_calib_done = 1'b0; user_lnk_up = 1'b0;
    bus.req_cmd_valid = '0; bus.req_cmd_wr = '0; bus.req_cmd_addr = '0; bus.req_cmd_len = '0;
    bus.req_wdata = '0; bus.req_wvalid = '0; bus.req_wlast = '0; bus.req_rready = '0;
    bus.ddr_cmd_ready = 1'b0; bus.ddr_wready = 1'b0; bus.ddr_rdata = '0;
    bus.ddr_rvalid = 1'b0; bus.ddr_rlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arb_ready", arb_ready, 0);
    check("rst_err", err_sticky, 0);
    check("rst_cmd", {bus.ddr_cmd_valid, bus.ddr_cmd_wr, bus.ddr_cmd_len, bus.ddr_cmd_addr}, 0);
    check("rst_w", {bus.ddr_wvalid, bus.ddr_wlast, bus.ddr_wdata[31:0]}, 0);
    check("rst_ready", {bus.req_cmd_ready, bus.req_wready, bus.req_rvalid, bus.ddr_rready}, 0);

    // 1: no grant before calibration; grant two cycles after calibration completes
    @(posedge clk); #1;
    sys_rst_n = 1'b1; user_lnk_up = 1'b1;
    set_cmd(0, 1, 0, addr_of(0, 1), 0);
    exp_cmd.push_back(pk(0, 0, addr_of(0, 1)));
    exp_tag.push_back(1'b0);
    repeat (5) cyc();
    check("t1_no_arb_ready", arb_ready, 0);
    check("t1_no_cmd", bus.ddr_cmd_valid, 0);
    check("t1_no_ready", bus.req_cmd_ready, 0);
    ddr_calib_done = 1'b1;
    cyc();
    check("t1_arb_ready", arb_ready, 1);
    check("t1_cmd_1cyc", bus.ddr_cmd_valid, 0);
    cyc();
    check("t1_cmd_2cyc", bus.ddr_cmd_valid, 1);
    check("t1_addr", bus.ddr_cmd_addr, addr_of(0, 1));
    check("t1_ready_wait", bus.req_cmd_ready, 0);
    bus.ddr_cmd_ready = 1'b1; bus.ddr_wready = 1'b1;
    cyc();
    check("t1_hs", hs_cmd, 2'b01);
    bus.req_cmd_valid[0] = 1'b0;
    return_read(1);

    // 2: both read every cycle; req0 won last, so the first tie goes to req1
    for (int unsigned i = 0; i < 8; i++) begin
      exp_cmd.push_back(pk(0, 0, addr_of((i % 2 == 0) ? 1 : 0, i / 2)));
      exp_tag.push_back((i % 2) == 0);
    end
    cnt[0] = 0; cnt[1] = 0; budget = 0;
    set_cmd(0, 1, 0, addr_of(0, 0), 0);
    set_cmd(1, 1, 0, addr_of(1, 0), 0);
    while ((cnt[0] < 4 || cnt[1] < 4) && budget < 60) begin
      cyc();
      budget++;
      for (int unsigned r = 0; r < 2; r++) begin
        if (hs_cmd[r]) begin
          cnt[r]++;
          if (cnt[r] == 4) bus.req_cmd_valid[r] = 1'b0;
          else bus.req_cmd_addr[r*AW +: AW] = addr_of(r, cnt[r]);
        end
      end
    end
    check("t2_cnt", {cnt[0][7:0], cnt[1][7:0]}, 16'h0404);
    for (int unsigned i = 0; i < 8; i++) return_read(1 + i % 3);

    // 3: req1 4-beat write locks the port; req0's pending read follows it
    exp_cmd.push_back(pk(1, 3, addr_of(1, 9)));
    exp_cmd.push_back(pk(0, 0, addr_of(0, 9)));
    for (int unsigned b = 0; b < 4; b++) exp_beat.push_back({b == 3, 32'h3000_0000 + b});
    exp_tag.push_back(1'b0);
    set_cmd(1, 1, 1, addr_of(1, 9), 3);
    set_w(1, 1, 32'h3000_0000, 0);
    set_cmd(0, 1, 0, addr_of(0, 9), 0);
    beats = 0; done0 = 0; done1 = 0; budget = 0;
    while (!(done0 && done1 && beats == 4) && budget < 40) begin
      cyc();
      budget++;
      check("t3_wready0", bus.req_wready[0], 0);
      if (hs_cmd[1]) begin bus.req_cmd_valid[1] = 1'b0; done1 = 1; end
      if (hs_cmd[0]) begin bus.req_cmd_valid[0] = 1'b0; done0 = 1; end
      if (hs_w[1]) begin
        beats++;
        if (beats == 4) set_w(1, 0, 0, 0);
        else set_w(1, 1, 32'h3000_0000 + beats, beats == 3);
      end
    end
    check("t3_done", {done0, done1, beats[3:0]}, {2'b11, 4'd4});
    check("t3_err", err_sticky, 0);
    return_read(2);

    // 4: req0 signals wlast early on beat 2; the arbiter still ends the burst on beat 4
    exp_cmd.push_back(pk(1, 3, addr_of(0, 20)));
    for (int unsigned b = 0; b < 4; b++) exp_beat.push_back({b == 3, 32'h4000_0000 + b});
    set_cmd(0, 1, 1, addr_of(0, 20), 3);
    set_w(0, 1, 32'h4000_0000, 0);
    beats = 0; budget = 0;
    while (beats < 4 && budget < 40) begin
      cyc();
      budget++;
      if (hs_cmd[0]) bus.req_cmd_valid[0] = 1'b0;
      if (hs_w[0]) begin
        beats++;
        check("t4_err", err_sticky, beats >= 2);
        if (beats == 4) set_w(0, 0, 0, 0);
        else set_w(0, 1, 32'h4000_0000 + beats, beats == 1);
      end
    end
    check("t4_beats", beats, 4);
    cyc();
    check("t4_burst_over", bus.ddr_wvalid, 0);

    // 5: 16 reads fill the tag FIFO; a write still passes, the 17th read waits for a pop
    for (int unsigned i = 0; i < 16; i++) begin
      exp_cmd.push_back(pk(0, 0, addr_of(0, 32 + i)));
      exp_tag.push_back(1'b0);
    end
    exp_cmd.push_back(pk(1, 0, addr_of(1, 50)));
    exp_beat.push_back({1'b1, 32'h5000_0000});
    exp_cmd.push_back(pk(0, 0, addr_of(0, 48)));
    exp_tag.push_back(1'b0);
    cnt[0] = 0; budget = 0;
    set_cmd(0, 1, 0, addr_of(0, 32), 0);
    while (cnt[0] < 16 && budget < 80) begin
      cyc();
      budget++;
      if (hs_cmd[0]) begin
        cnt[0]++;
        bus.req_cmd_addr[0 +: AW] = addr_of(0, 32 + cnt[0]);
      end
    end
    check("t5_16_reads", cnt[0], 16);
    set_cmd(1, 1, 1, addr_of(1, 50), 0);
    set_w(1, 1, 32'h5000_0000, 1);
    done1 = 0; budget = 0;
    while (!done1 && budget < 20) begin
      cyc();
      budget++;
      check("t5_read_held", hs_cmd[0], 0);
      if (hs_cmd[1]) bus.req_cmd_valid[1] = 1'b0;
      if (hs_w[1]) begin done1 = 1; set_w(1, 0, 0, 0); end
    end
    check("t5_write_done", done1, 1);
    repeat (4) begin
      cyc();
      check("t5_blocked", {bus.ddr_cmd_valid, bus.req_cmd_ready}, 0);
    end
    return_read(1);
    done0 = hs_cmd[0]; budget = 0;
    while (!done0 && budget < 10) begin
      cyc();
      budget++;
      done0 = hs_cmd[0];
    end
    check("t5_17th_issued", done0, 1);
    bus.req_cmd_valid[0] = 1'b0;
    for (int unsigned i = 0; i < 16; i++) return_read(1);

    // 6: reset during write beat 2, then req0 wins the first tie
    for (int unsigned b = 0; b < 4; b++) exp_beat.push_back({b == 3, 32'h6000_0000 + b});
    exp_cmd.push_back(pk(1, 3, addr_of(1, 60)));
    set_cmd(1, 1, 1, addr_of(1, 60), 3);
    set_w(1, 1, 32'h6000_0000, 0);
    beats = 0; budget = 0;
    while (beats < 1 && budget < 20) begin
      cyc();
      budget++;
      if (hs_cmd[1]) bus.req_cmd_valid[1] = 1'b0;
      if (hs_w[1]) begin beats++; set_w(1, 1, 32'h6000_0001, 0); end
    end
    check("t6_beat1", beats, 1);
    check("t6_in_burst", bus.ddr_wvalid, 1);
    sys_rst_n = 1'b0;
    exp_cmd.delete(); exp_beat.delete(); exp_tag.delete();
    set_w(1, 0, 0, 0);
    set_cmd(0, 1, 0, addr_of(0, 70), 0);
    set_cmd(1, 1, 0, addr_of(1, 70), 0);
    #1;
    check("t6_async_w", {bus.ddr_wvalid, bus.ddr_wlast, bus.req_wready}, 0);
    @(negedge clk);
    check("t6_rst_out", {arb_ready, err_sticky, bus.ddr_cmd_valid, bus.req_cmd_ready,
                         bus.ddr_wvalid, bus.ddr_rready, bus.req_rvalid}, 0);
`ifdef DDR_ARB_STATS_EN
    check("t6_stats_zero", {stat_grant0, stat_grant1}, 0);
    check("t6_stall_zero", stat_stall, 0);
`endif
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    exp_cmd.push_back(pk(0, 0, addr_of(0, 70)));
    exp_cmd.push_back(pk(0, 0, addr_of(1, 70)));
    exp_tag.push_back(1'b0);
    exp_tag.push_back(1'b1);
    done0 = 0; done1 = 0; budget = 0;
    while (!(done0 && done1) && budget < 20) begin
      cyc();
      budget++;
      if (hs_cmd[0]) begin bus.req_cmd_valid[0] = 1'b0; done0 = 1; end
      if (hs_cmd[1]) begin bus.req_cmd_valid[1] = 1'b0; done1 = 1; end
    end
    check("t6_both_done", {done0, done1}, 2'b11);
    check("t6_err_cleared", err_sticky, 0);
`ifdef DDR_ARB_STATS_EN
    check("t6_stats_grants", {stat_grant0, stat_grant1}, {32'd1, 32'd1});
`endif

    // 7: head tag gates ddr_rready; read data with an empty FIFO flags an error
    bus.req_rready = 2'b10;
    bus.ddr_rvalid = 1'b1; bus.ddr_rlast = 1'b1;
    bus.ddr_rdata  = {{(DW-32){1'b0}}, rd_word};
    @(negedge clk);
    check("t7_head_route", bus.req_rvalid, 2'b01);
    check("t7_head_blocked", bus.ddr_rready, 0);
    @(posedge clk); #1;
    return_read(1);
    return_read(1);
    bus.ddr_rvalid = 1'b1; bus.ddr_rlast = 1'b1;
    @(negedge clk);
    check("t7_empty_rready", {bus.ddr_rready, bus.req_rvalid}, 0);
    @(posedge clk); #1;
    bus.ddr_rvalid = 1'b0; bus.ddr_rlast = 1'b0;
    check("t7_empty_err", err_sticky, 1);
    check("t7_queues_drained", exp_cmd.size() + exp_beat.size() + exp_tag.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
